vga_timing_gen: RTL and testbench

- Parametrised raster timing generator; successor to the fixed 640x480 controller.
- Sits between the pixel clock domain (clk_25) and the VGA DAC / frame-buffer reader.
- Generates sync, blank and data-enable signals for any mode, with configurable sync polarity and an enable/stall input.
- Adds frame and line strobes, and a prefetch coordinate stream that runs FETCH_LAT cycles ahead so the NPU result buffer can be read with pipeline latency.

---
 rtl/vga_timing_gen_if.sv | 27 ++
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 tb/tb_vga_timing_gen.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of vga_timing_gen: sync, blank, pixel coordinates,
// line/frame strobes and the prefetch coordinate stream.
interface vga_timing_gen_if #(
  parameter int CW = 10
);
  logic          vga_hsync;
  logic          vga_vsync;
  logic          sync_b;
  logic          sync_blank;
  logic [CW-1:0] px_x;
  logic [CW-1:0] px_y;
  logic          frame_start;
  logic          line_start;
  logic          fetch_valid;
  logic [CW-1:0] fetch_x;
  logic [CW-1:0] fetch_y;

  modport master (
    output vga_hsync, vga_vsync, sync_b, sync_blank, px_x, px_y,
           frame_start, line_start, fetch_valid, fetch_x, fetch_y
  );

  modport slave (
    input  vga_hsync, vga_vsync, sync_b, sync_blank, px_x, px_y,
           frame_start, line_start, fetch_valid, fetch_x, fetch_y
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. A display counter pair (hc, vc)
// and a fetch counter pair running FETCH_LAT clocks ahead are decoded into
// registered sync/blank/coordinate/strobe outputs one clock later.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int FETCH_LAT = 2,
  parameter int CW        = 10
) (
  input  logic             clk_25,
  input  logic             rst_n,
  input  logic             en,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO   = H_ACTIVE + H_FP;
  localparam int HS_HI   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_LO   = V_ACTIVE + V_FP;
  localparam int VS_HI   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] FC_X0  = CW'(FETCH_LAT);
  localparam logic          HS_ON  = (HS_POL != 0);
  localparam logic          VS_ON  = (VS_POL != 0);

  // Inclusive-start, exclusive-end window test done in int so that an end
  // equal to the total count never wraps in CW bits.
  function automatic logic in_window(input logic [CW-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

  function automatic logic [CW-1:0] next_x(input logic [CW-1:0] x);
    return (x == H_LAST) ? '0 : x + 1'b1;
  endfunction

  function automatic logic [CW-1:0] next_y(input logic [CW-1:0] x, input logic [CW-1:0] y);
    if (x != H_LAST) return y;
    return (y == V_LAST) ? '0 : y + 1'b1;
  endfunction

  function automatic logic is_active(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return (int'(x) < H_ACTIVE) && (int'(y) < V_ACTIVE);
  endfunction

  // stage p0: raster counters
  logic [CW-1:0] r_hc_p0, r_vc_p0;
  logic [CW-1:0] r_fcx_p0, r_fcy_p0;

  // stage p1: registered decode
  logic          r_hsync_p1, r_vsync_p1, r_sync_b_p1, r_blank_p1;
  logic [CW-1:0] r_px_x_p1, r_px_y_p1;
  logic          r_frame_p1, r_line_p1;
  logic          r_fvalid_p1;
  logic [CW-1:0] r_fx_p1, r_fy_p1;

  logic w_hs_win, w_vs_win;
  assign w_hs_win = in_window(r_hc_p0, HS_LO, HS_HI);
  assign w_vs_win = in_window(r_vc_p0, VS_LO, VS_HI);

  // Display and fetch counters advance together, so the fetch pair keeps a
  // constant raster-order lead of FETCH_LAT enabled clocks.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_hc_p0  <= '0;
      r_vc_p0  <= '0;
      r_fcx_p0 <= FC_X0;
      r_fcy_p0 <= '0;
    end else if (en) begin
      r_hc_p0  <= next_x(r_hc_p0);
      r_vc_p0  <= next_y(r_hc_p0, r_vc_p0);
      r_fcx_p0 <= next_x(r_fcx_p0);
      r_fcy_p0 <= next_y(r_fcx_p0, r_fcy_p0);
    end
  end

  // Decode counter positions into registered outputs; frozen while en=0.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync_p1  <= ~HS_ON;
      r_vsync_p1  <= ~VS_ON;
      r_sync_b_p1 <= 1'b1;
      r_blank_p1  <= 1'b0;
      r_px_x_p1   <= '0;
      r_px_y_p1   <= '0;
      r_frame_p1  <= 1'b0;
      r_line_p1   <= 1'b0;
      r_fvalid_p1 <= 1'b0;
      r_fx_p1     <= '0;
      r_fy_p1     <= '0;
    end else if (en) begin
      r_hsync_p1  <= w_hs_win ? HS_ON : ~HS_ON;
      r_vsync_p1  <= w_vs_win ? VS_ON : ~VS_ON;
      r_sync_b_p1 <= ~(w_hs_win | w_vs_win);
      r_blank_p1  <= is_active(r_hc_p0, r_vc_p0);
      r_px_x_p1   <= r_hc_p0;
      r_px_y_p1   <= r_vc_p0;
      r_frame_p1  <= (r_hc_p0 == '0) && (r_vc_p0 == '0);
      r_line_p1   <= (r_hc_p0 == '0);
      r_fvalid_p1 <= is_active(r_fcx_p0, r_fcy_p0);
      r_fx_p1     <= r_fcx_p0;
      r_fy_p1     <= r_fcy_p0;
    end
  end

  assign vga.vga_hsync   = r_hsync_p1;
  assign vga.vga_vsync   = r_vsync_p1;
  assign vga.sync_b      = r_sync_b_p1;
  assign vga.sync_blank  = r_blank_p1;
  assign vga.px_x        = r_px_x_p1;
  assign vga.px_y        = r_px_y_p1;
  assign vga.frame_start = r_frame_p1;
  assign vga.line_start  = r_line_p1;
  assign vga.fetch_valid = r_fvalid_p1;
  assign vga.fetch_x     = r_fx_p1;
  assign vga.fetch_y     = r_fy_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default mode, small mode with
// active-high syncs and FETCH_LAT=3, small mode with FETCH_LAT=0) checked
// cycle by cycle against a raster reference model through a scoreboard.
module tb_vga_timing_gen;

  typedef struct {
    logic        hs, vs, sb, bl, fs, ls, fv;
    logic [15:0] x, y, fx, fy;
  } vexp_t;

  typedef struct {
    logic        fv;
    logic [15:0] fx, fy;
  } fent_t;

  logic clk_25 = 1'b0;
  logic rst_n;
  logic en;

  always #5 clk_25 = ~clk_25;

  vga_timing_gen_if #(.CW(10)) ifA ();
  vga_timing_gen_if #(.CW(10)) ifB ();
  vga_timing_gen_if #(.CW(10)) ifC ();

  vga_timing_gen u_a (.clk_25(clk_25), .rst_n(rst_n), .en(en), .vga(ifA));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .FETCH_LAT(3), .CW(10)
  ) u_b (.clk_25(clk_25), .rst_n(rst_n), .en(en), .vga(ifB));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .FETCH_LAT(0), .CW(10)
  ) u_c (.clk_25(clk_25), .rst_n(rst_n), .en(en), .vga(ifC));

  int    HA [3] = '{640, 8, 8};
  int    HF [3] = '{16, 2, 2};
  int    HS [3] = '{96, 2, 2};
  int    HB [3] = '{48, 2, 2};
  int    VA [3] = '{480, 4, 4};
  int    VF [3] = '{10, 1, 1};
  int    VS [3] = '{2, 1, 1};
  int    VB [3] = '{33, 1, 1};
  int    HP [3] = '{0, 1, 0};
  int    VP [3] = '{0, 1, 0};
  int    LAT[3] = '{2, 3, 0};
  string nm [3] = '{"A", "B", "C"};

  int    mx [3];
  int    my [3];
  vexp_t held[3];
  vexp_t sbq[$];
  fent_t fq[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int htot(int i);
    return HA[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int vtot(int i);
    return VA[i] + VF[i] + VS[i] + VB[i];
  endfunction

  // Expected outputs for raster position (x, y) of instance i.
  function automatic vexp_t model(int i, int x, int y);
    vexp_t e;
    int    ht, vt, lin, fx, fy;
    logic  hw, vw;
    ht   = htot(i);
    vt   = vtot(i);
    hw   = (x >= HA[i] + HF[i]) && (x < HA[i] + HF[i] + HS[i]);
    vw   = (y >= VA[i] + VF[i]) && (y < VA[i] + VF[i] + VS[i]);
    e.hs = (hw == (HP[i] != 0));
    e.vs = (vw == (VP[i] != 0));
    e.sb = !(hw || vw);
    e.bl = (x < HA[i]) && (y < VA[i]);
    e.fs = (x == 0) && (y == 0);
    e.ls = (x == 0);
    lin  = (y * ht + x + LAT[i]) % (ht * vt);
    fx   = lin % ht;
    fy   = lin / ht;
    e.fv = (fx < HA[i]) && (fy < VA[i]);
    e.x  = 16'(x);
    e.y  = 16'(y);
    e.fx = 16'(fx);
    e.fy = 16'(fy);
    return e;
  endfunction

  function automatic vexp_t rst_exp(int i);
    vexp_t e;
    e.hs = (HP[i] == 0);
    e.vs = (VP[i] == 0);
    e.sb = 1'b1;
    e.bl = 1'b0;
    e.fs = 1'b0;
    e.ls = 1'b0;
    e.fv = 1'b0;
    e.x  = '0;
    e.y  = '0;
    e.fx = '0;
    e.fy = '0;
    return e;
  endfunction

  function automatic vexp_t get_act(int i);
    vexp_t a;
    case (i)
      0: a = '{ifA.vga_hsync, ifA.vga_vsync, ifA.sync_b, ifA.sync_blank, ifA.frame_start,
               ifA.line_start, ifA.fetch_valid, 16'(ifA.px_x), 16'(ifA.px_y),
               16'(ifA.fetch_x), 16'(ifA.fetch_y)};
      1: a = '{ifB.vga_hsync, ifB.vga_vsync, ifB.sync_b, ifB.sync_blank, ifB.frame_start,
               ifB.line_start, ifB.fetch_valid, 16'(ifB.px_x), 16'(ifB.px_y),
               16'(ifB.fetch_x), 16'(ifB.fetch_y)};
      default: a = '{ifC.vga_hsync, ifC.vga_vsync, ifC.sync_b, ifC.sync_blank, ifC.frame_start,
               ifC.line_start, ifC.fetch_valid, 16'(ifC.px_x), 16'(ifC.px_y),
               16'(ifC.fetch_x), 16'(ifC.fetch_y)};
    endcase
    return a;
  endfunction

  task automatic cmp(input int i, input vexp_t e, input vexp_t a);
    chk({nm[i], ".hsync"}, a.hs, e.hs);
    chk({nm[i], ".vsync"}, a.vs, e.vs);
    chk({nm[i], ".sync_b"}, a.sb, e.sb);
    chk({nm[i], ".blank"}, a.bl, e.bl);
    chk({nm[i], ".frame_start"}, a.fs, e.fs);
    chk({nm[i], ".line_start"}, a.ls, e.ls);
    chk({nm[i], ".fetch_valid"}, a.fv, e.fv);
    chk({nm[i], ".px_x"}, a.x, e.x);
    chk({nm[i], ".px_y"}, a.y, e.y);
    chk({nm[i], ".fetch_x"}, a.fx, e.fx);
    chk({nm[i], ".fetch_y"}, a.fy, e.fy);
  endtask

  // One clock: push expected outputs, clock, then pop and compare.
  task automatic step(input logic e);
    fent_t f;
    en = e;
    for (int i = 0; i < 3; i++) begin
      if (e) begin
        held[i] = model(i, mx[i], my[i]);
        mx[i]++;
        if (mx[i] == htot(i)) begin
          mx[i] = 0;
          my[i]++;
          if (my[i] == vtot(i)) my[i] = 0;
        end
      end
      sbq.push_back(held[i]);
    end
    @(posedge clk_25);
    #1;
    for (int i = 0; i < 3; i++) cmp(i, sbq.pop_front(), get_act(i));
    chk("C.fx_eq_px", 32'(ifC.fetch_x), 32'(ifC.px_x));
    chk("C.fy_eq_py", 32'(ifC.fetch_y), 32'(ifC.px_y));
    chk("C.fv_eq_bl", 32'(ifC.fetch_valid), 32'(ifC.sync_blank));
    if (e) begin
      f = '{ifB.fetch_valid, 16'(ifB.fetch_x), 16'(ifB.fetch_y)};
      fq.push_back(f);
      if (fq.size() > 3) begin
        f = fq.pop_front();
        chk("B.lead_x", 32'(ifB.px_x), 32'(f.fx));
        chk("B.lead_y", 32'(ifB.px_y), 32'(f.fy));
        chk("B.lead_v", 32'(ifB.sync_blank), 32'(f.fv));
      end
    end
  endtask

  task automatic rst_expect();
    for (int i = 0; i < 3; i++) begin
      held[i] = rst_exp(i);
      mx[i]   = 0;
      my[i]   = 0;
    end
    fq.delete();
  endtask

  task automatic rst_check();
    for (int i = 0; i < 3; i++) sbq.push_back(held[i]);
    for (int i = 0; i < 3; i++) cmp(i, sbq.pop_front(), get_act(i));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   hs_a, fall1, fall2, fall_x, nfall;
    int   bl_b, ls_b, fs_b, hs_b, vs_b, sb_b;
    logic prev_a;

    rst_n = 1'b0;
    en    = 1'b0;
    repeat (2) @(posedge clk_25);
    #1;
    rst_expect();
    rst_check();
    #2 rst_n = 1'b1;

    hs_a = 0; fall1 = 0; fall2 = 0; fall_x = 0; nfall = 0;
    bl_b = 0; ls_b = 0; fs_b = 0; hs_b = 0; vs_b = 0; sb_b = 0;
    prev_a = 1'b1;
    for (int n = 0; n < 1700; n++) begin
      step(1'b1);
      if (n < 98) begin
        if (ifB.sync_blank)  bl_b++;
        if (ifB.line_start)  ls_b++;
        if (ifB.frame_start) fs_b++;
        if (ifB.vga_hsync)   hs_b++;
        if (ifB.vga_vsync)   vs_b++;
        if (!ifB.sync_b)     sb_b++;
      end
      if (n < 1600 && !ifA.vga_hsync) hs_a++;
      if (prev_a && !ifA.vga_hsync) begin
        if (nfall == 0) begin
          fall1  = n;
          fall_x = int'(ifA.px_x);
        end else if (nfall == 1) begin
          fall2 = n;
        end
        nfall++;
      end
      prev_a = ifA.vga_hsync;
    end
    chk("A.hs_low_clocks", hs_a, 192);
    chk("A.hs_start_x", fall_x, 656);
    chk("A.hs_period", fall2 - fall1, 800);
    chk("B.blank_clocks", bl_b, 32);
    chk("B.line_starts", ls_b, 7);
    chk("B.frame_starts", fs_b, 1);
    chk("B.hs_high_clocks", hs_b, 14);
    chk("B.vs_high_clocks", vs_b, 14);
    chk("B.sync_b_low", sb_b, 26);

    // Stall patterns: explicit 1,0,0,1 bursts then pseudo-random enable.
    for (int k = 0; k < 20; k++) begin
      step(1'b1);
      step(1'b0);
      step(1'b0);
      step(1'b1);
    end
    for (int k = 0; k < 600; k++) step($urandom_range(0, 3) != 0);

    // Asynchronous reset mid-frame, asserted between clock edges.
    for (int k = 0; k < 37; k++) step(1'b1);
    #3 rst_n = 1'b0;
    #1;
    rst_expect();
    rst_check();
    en = 1'b1;
    @(posedge clk_25);
    #1;
    rst_check();
    #2 rst_n = 1'b1;
    step(1'b1);
    chk("A.rel_frame_start", 32'(ifA.frame_start), 1);
    chk("A.rel_blank", 32'(ifA.sync_blank), 1);
    chk("A.rel_fetch_x", 32'(ifA.fetch_x), 2);
    chk("B.rel_fetch_x", 32'(ifB.fetch_x), 3);
    for (int k = 0; k < 300; k++) step(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
